bram_wm: RTL and testbench
==========================

Name: bram_wm

Overview:
- Parametrised successor of the team's 32-word single-port BRAM; the processor data/instruction bus sees the same cs/rd/wr interface.
- Adds a configurable depth and width, honoured per-byte write masks, and an optional output register stage.
- Adds a read-valid pulse, an out-of-range error flag, and a zero-fill engine that runs after reset.
- Sits between the core's memory bus and on-chip SRAM/BRAM.

Parameters:
- ADDR_W, 5, word-address bits; DEPTH = 2**ADDR_W words.
- DATA_W, 32, word width; must be a multiple of 8; NB = DATA_W/8 byte lanes.
- OUT_REG, 0, 1 adds a registered output stage (read latency 2 instead of 1).
- CLEAR_ON_RESET, 1, 1 zero-fills the whole array after reset deassertion.

Ports:
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  asynchronous, active-low reset.
- mem_addr  in  32  byte address; word index = mem_addr[ADDR_W+1:2].
- cs  in  1  chip select.
- rd  in  1  read request, qualified by cs.
- wr  in  1  write request, qualified by cs.
- mem_wdata  in  DATA_W  write data.
- mem_wmask  in  NB  byte enables; 1 = write that lane.
- mem_rdata  out  DATA_W  read data.
- mem_rvalid  out  1  one-cycle pulse; mem_rdata is valid in that cycle.
- mem_busy  out  1  high while the zero-fill runs; requests are dropped.
- mem_err  out  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Reset (resetn low, async):
  - mem_rdata=0, mem_rvalid=0, mem_err=0, pipeline valid bits=0, clear counter=0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - mem_busy reflects the state (high in CLEAR) from reset assertion onward.
  - The array itself is not reset asynchronously.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes all-zero to word[cnt], then cnt++.
  - At cnt == DEPTH-1 the write occurs and the state moves to IDLE next cycle: exactly DEPTH busy cycles after resetn rises.
  - cs/rd/wr are ignored: no write, no rvalid, no err.
- Reset mid-CLEAR: the counter restarts from 0 and the full DEPTH-cycle fill is repeated.
- IDLE, read (cs & rd at edge N):
  - OUT_REG=0: mem_rdata updated and mem_rvalid=1 after edge N (one cycle).
  - OUT_REG=1: both appear after edge N+1.
  - mem_rdata holds its last value until the next read completes. Back-to-back reads are fully pipelined, one per cycle.
- IDLE, write (cs & wr): lane i of word[idx] is written iff mem_wmask[i]=1. mem_wmask=0 is a no-op and raises no error.
- Simultaneous cs & rd & wr to the same word: read-before-write. The read returns the old word; the new data is visible to the next read.
- Out of range: mem_addr[31:ADDR_W+2] != 0 with cs & (rd|wr).
  - mem_err pulses one cycle, aligned with when rvalid would be, or 1 cycle after a write.
  - Writes are suppressed.
  - Reads return mem_rdata=0 with mem_rvalid=1, so the bus never hangs.
- mem_addr[1:0] is ignored; no alignment error.
- cs low: rd and wr are ignored, no outputs change except rvalid/err returning to 0.

Decomposition:
- Shared package bram_pkg:
  - State encoding ST_CLEAR=1'b0, ST_IDLE=1'b1.
  - BYTE_W=8.
  - Function nb(DATA_W).
- One sub-module, bram_wm_array:
  - Pure synchronous storage: DEPTH x DATA_W, per-lane write enables, registered read port, no reset.
  - Written for BRAM inference.
- bram_wm holds the FSM, clear counter, address decode/range check, output register and valid/err pipeline, and muxes the clear-engine write onto the array port.

Test Plan:
- ADDR_W=5, array preloaded with 0xDEADBEEF, release resetn -> mem_busy high exactly 32 cycles. A read issued during busy gets no rvalid. Reads of addr 0x00..0x7C after busy return 0x00000000.
- Write 0x11223344 mask 4'hF to 0x10, then 0xAABBCCDD mask 4'b0101 -> read 0x10 returns 0x11BB33DD, rvalid exactly 1 cycle after rd (OUT_REG=0) and 2 cycles after (OUT_REG=1).
- word[3]=0x0; same cycle rd & wr 0xCAFEF00D mask 4'hF to 0x0C -> returned data 0x00000000; the following read returns 0xCAFEF00D.
- ADDR_W=5, write 0x12345678 to 0x80 -> mem_err pulse, word[0] unchanged. Read 0x80 -> rdata 0, rvalid=1, err=1.
- Assert resetn low at clear cycle 10, release -> busy lasts a fresh 32 cycles, all words read 0.
- Reads at 0x00,0x04,0x08 on consecutive cycles -> three consecutive rvalid pulses with matching data.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the parametrised single-port BRAM.
// State encoding, byte-lane width and lane-count helper.
package bram_pkg;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam int BYTE_W = 8;

    function automatic int nb(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/bram_wm_array.sv
// Plain synchronous storage, one write port with per-lane enables
// and one registered read port; no reset so it maps onto block RAM.
module bram_wm_array
    import bram_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk_i,
    input  logic [DATA_W/BYTE_W-1:0] we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     re_i,
    input  logic [ADDR_W-1:0]        raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    localparam int NB    = nb(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Lane-masked write and read-before-write registered read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB; i++) begin
            if (we_i[i]) begin
                mem_q[waddr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_wm.sv
// Bus-facing BRAM wrapper: zero-fill engine, range check,
// read-valid / error pipeline and optional output register.
module bram_wm
    import bram_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter bit OUT_REG        = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              mem_addr,
    input  logic                     cs,
    input  logic                     rd,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W/BYTE_W-1:0] mem_wmask,
    output logic [DATA_W-1:0]        mem_rdata,
    output logic                     mem_rvalid,
    output logic                     mem_busy,
    output logic                     mem_err
);

    localparam int NB = nb(DATA_W);
    localparam logic [0:0] ST_RST = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              idle;
    logic [ADDR_W-1:0] idx;
    logic              oor;
    logic              rd_req, wr_req;
    logic              rd_ok, wr_ok;

    logic [NB-1:0]     arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    logic              v1_q, rerr1_q, werr1_q, zero_q;
    logic [DATA_W-1:0] rd_word;

    logic              unused_lsb;

    assign unused_lsb = ^mem_addr[1:0];

    assign idle   = (state_q == ST_IDLE);
    assign idx    = mem_addr[ADDR_W+1:2];
    assign oor    = |mem_addr[31:ADDR_W+2];
    assign rd_req = idle & cs & rd;
    assign wr_req = idle & cs & wr;
    assign rd_ok  = rd_req & ~oor;
    assign wr_ok  = wr_req & ~oor;

    // Clear engine walks every word once, then hands over to the bus.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!idle) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = ST_IDLE;
            end
        end
    end

    // FSM and clear counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear engine owns the write port while busy.
    always_comb begin
        arr_we    = wr_ok ? mem_wmask : '0;
        arr_waddr = idx;
        arr_wdata = mem_wdata;
        if (!idle) begin
            arr_we    = '1;
            arr_waddr = cnt_q;
            arr_wdata = '0;
        end
    end

    bram_wm_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .re_i    (rd_ok),
        .raddr_i (idx),
        .rdata_o (arr_rdata)
    );

    // First pipeline stage: valid, errors, and zero-select for
    // out-of-range reads (the array register keeps its old word).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1_q    <= 1'b0;
            rerr1_q <= 1'b0;
            werr1_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            v1_q    <= rd_req;
            rerr1_q <= rd_req & oor;
            werr1_q <= wr_req & ~rd_req & oor;
            if (rd_req) begin
                zero_q <= oor;
            end
        end
    end

    assign rd_word = zero_q ? '0 : arr_rdata;

    assign mem_busy = ~idle;

    if (OUT_REG) begin : g_oreg
        logic              v2_q, rerr2_q;
        logic [DATA_W-1:0] rdata2_q;

        // Extra output stage, loaded only when a read completes.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                v2_q     <= 1'b0;
                rerr2_q  <= 1'b0;
                rdata2_q <= '0;
            end else begin
                v2_q    <= v1_q;
                rerr2_q <= rerr1_q;
                if (v1_q) begin
                    rdata2_q <= rd_word;
                end
            end
        end

        assign mem_rdata  = rdata2_q;
        assign mem_rvalid = v2_q;
        assign mem_err    = rerr2_q | werr1_q;
    end else begin : g_noreg
        assign mem_rdata  = rd_word;
        assign mem_rvalid = v1_q;
        assign mem_err    = rerr1_q | werr1_q;
    end

endmodule

// File: tb/tb_bram_wm.sv
// Directed bench for bram_wm: one instance without and one with
// the output register, both driven by the same bus.
module tb_bram_wm;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] mem_addr;
    logic        cs, rd, wr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;

    logic [31:0] rdata0, rdata1;
    logic        rv0, rv1, busy0, busy1, err0, err1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_wm #(
        .ADDR_W(5), .DATA_W(32), .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)
    ) u_dut (
        .clk(clk), .resetn(resetn), .mem_addr(mem_addr),
        .cs(cs), .rd(rd), .wr(wr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(rdata0), .mem_rvalid(rv0),
        .mem_busy(busy0), .mem_err(err0)
    );

    bram_wm #(
        .ADDR_W(5), .DATA_W(32), .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1)
    ) u_dut_r (
        .clk(clk), .resetn(resetn), .mem_addr(mem_addr),
        .cs(cs), .rd(rd), .wr(wr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(rdata1), .mem_rvalid(rv1),
        .mem_busy(busy1), .mem_err(err1)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        cs = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic drive(input logic [31:0] a, input logic r,
                         input logic w, input logic [31:0] d,
                         input logic [3:0] m);
        mem_addr  = a;
        cs        = 1'b1;
        rd        = r;
        wr        = w;
        mem_wdata = d;
        mem_wmask = m;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic experr);
        drive(a, 1'b0, 1'b1, d, m);
        tick();
        idle();
        check("werr0", {31'd0, err0}, {31'd0, experr});
        check("werr1", {31'd0, err1}, {31'd0, experr});
    endtask

    task automatic rdwr(input logic [31:0] a, input logic [31:0] exp,
                        input logic experr, input logic w,
                        input logic [31:0] d, input logic [3:0] m);
        drive(a, 1'b1, w, d, m);
        tick();
        idle();
        check("rv0", {31'd0, rv0}, 32'd1);
        check("rdata0", rdata0, exp);
        check("rerr0", {31'd0, err0}, {31'd0, experr});
        check("rv1_early", {31'd0, rv1}, 32'd0);
        tick();
        check("rv0_drop", {31'd0, rv0}, 32'd0);
        check("rv1", {31'd0, rv1}, 32'd1);
        check("rdata1", rdata1, exp);
        check("rerr1", {31'd0, err1}, {31'd0, experr});
    endtask

    task automatic read(input logic [31:0] a, input logic [31:0] exp,
                        input logic experr);
        rdwr(a, exp, experr, 1'b0, 32'd0, 4'd0);
    endtask

    task automatic release_and_count(input string tag);
        int   n   = 0;
        logic saw = 1'b0;
        check({tag, "_busy_pre"}, {31'd0, busy0}, 32'd1);
        drive(32'd0, 1'b1, 1'b0, 32'd0, 4'd0);
        resetn = 1'b1;
        while (busy0 && n < 100) begin
            tick();
            n++;
            saw = saw | rv0 | rv1 | err0 | err1;
        end
        idle();
        check(tag, n, 32);
        check({tag, "_busy_r"}, {31'd0, busy1}, 32'd0);
        check({tag, "_no_resp"}, {31'd0, saw}, 32'd0);
        tick();
    endtask

    initial begin
        resetn    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        idle();
        tick();
        tick();
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_rv", {30'd0, rv0, rv1}, 32'd0);
        check("rst_err", {30'd0, err0, err1}, 32'd0);
        check("rst_busy", {30'd0, busy0, busy1}, 32'd3);

        release_and_count("busy_first");

        for (int i = 0; i < 32; i++) begin
            write(i * 4, 32'hDEADBEEF, 4'hF, 1'b0);
        end
        read(32'h14, 32'hDEADBEEF, 1'b0);

        resetn = 1'b0;
        tick();
        release_and_count("busy_clear");
        for (int i = 0; i < 32; i++) begin
            read(i * 4, 32'h0, 1'b0);
        end

        write(32'h10, 32'h11223344, 4'hF, 1'b0);
        write(32'h10, 32'hAABBCCDD, 4'b0101, 1'b0);
        read(32'h10, 32'h11BB33DD, 1'b0);
        write(32'h10, 32'hFFFFFFFF, 4'h0, 1'b0);
        read(32'h10, 32'h11BB33DD, 1'b0);

        rdwr(32'h0C, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF);
        read(32'h0C, 32'hCAFEF00D, 1'b0);
        read(32'h0F, 32'hCAFEF00D, 1'b0);

        write(32'h00, 32'hA0A0A0A0, 4'hF, 1'b0);
        write(32'h04, 32'hB1B1B1B1, 4'hF, 1'b0);
        write(32'h08, 32'hC2C2C2C2, 4'hF, 1'b0);
        drive(32'h00, 1'b1, 1'b0, 32'd0, 4'd0);
        tick();
        check("pipe_rv0_a", {31'd0, rv0}, 32'd1);
        check("pipe_d0_a", rdata0, 32'hA0A0A0A0);
        drive(32'h04, 1'b1, 1'b0, 32'd0, 4'd0);
        tick();
        check("pipe_rv0_b", {31'd0, rv0}, 32'd1);
        check("pipe_d0_b", rdata0, 32'hB1B1B1B1);
        check("pipe_rv1_a", {31'd0, rv1}, 32'd1);
        check("pipe_d1_a", rdata1, 32'hA0A0A0A0);
        drive(32'h08, 1'b1, 1'b0, 32'd0, 4'd0);
        tick();
        idle();
        check("pipe_rv0_c", {31'd0, rv0}, 32'd1);
        check("pipe_d0_c", rdata0, 32'hC2C2C2C2);
        check("pipe_rv1_b", {31'd0, rv1}, 32'd1);
        check("pipe_d1_b", rdata1, 32'hB1B1B1B1);
        tick();
        check("pipe_rv0_end", {31'd0, rv0}, 32'd0);
        check("pipe_rv1_c", {31'd0, rv1}, 32'd1);
        check("pipe_d1_c", rdata1, 32'hC2C2C2C2);
        check("pipe_d0_hold", rdata0, 32'hC2C2C2C2);
        tick();
        check("pipe_rv1_end", {31'd0, rv1}, 32'd0);

        write(32'h80, 32'h12345678, 4'hF, 1'b1);
        tick();
        check("oor_err_drop", {30'd0, err0, err1}, 32'd0);
        read(32'h00, 32'hA0A0A0A0, 1'b0);
        read(32'h80, 32'h0, 1'b1);
        read(32'h8000_0004, 32'h0, 1'b1);
        read(32'h04, 32'hB1B1B1B1, 1'b0);

        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        resetn = 1'b0;
        tick();
        check("mid_busy", {30'd0, busy0, busy1}, 32'd3);
        check("mid_rdata0", rdata0, 32'd0);
        release_and_count("busy_restart");
        for (int i = 0; i < 32; i++) begin
            read(i * 4, 32'h0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
